flp_accum_ctrl: RTL

Sequencer that reduces a stream of LEN floating-point operands (exp, mant) to a single sum through one shared FLP adder instance. It is used for the pseudo-softmax denominator. The block owns the adder's operand ports, holds them stable for the adder latency, and captures the result into a running accumulator. One transaction is one start, LEN accepted inputs and one done pulse.

---
 rtl/flp_accum_ctrl_if.sv | 14 +
 rtl/flp_accum_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/flp_accum_ctrl_if.sv
// Operand stream into the FLP accumulation controller. The producer is the
// master and the controller is the slave.
interface flp_accum_ctrl_if #(
  parameter int EXP_WIDTH  = 9,
  parameter int MANT_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [EXP_WIDTH-1:0]  in_exp;
  logic [MANT_WIDTH-1:0] in_mant;

  modport master (output in_valid, output in_exp, output in_mant, input in_ready);
  modport slave  (input in_valid, input in_exp, input in_mant, output in_ready);
endinterface

// File: rtl/flp_accum_ctrl.sv
// Reduces LEN (exp, mant) operands to one sum through a shared external FLP
// adder. Operands are held on add_* for ADD_LAT cycles before the result is taken.
module flp_accum_ctrl #(
  parameter int EXP_WIDTH  = 9,
  parameter int MANT_WIDTH = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int ADD_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  flp_accum_ctrl_if.slave       in_if,
  output logic [EXP_WIDTH-1:0]  add_exp1,
  output logic [MANT_WIDTH-1:0] add_mant1,
  output logic [EXP_WIDTH-1:0]  add_exp2,
  output logic [MANT_WIDTH-1:0] add_mant2,
  input  logic [EXP_WIDTH-1:0]  add_exp,
  input  logic [MANT_WIDTH-1:0] add_mant,
  output logic                  busy,
  output logic                  done,
  output logic [EXP_WIDTH-1:0]  sum_exp,
  output logic [MANT_WIDTH-1:0] sum_mant,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam int LAT_W = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_IN, ADD, DONE} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [EXP_WIDTH-1:0]  acc_exp;
  logic [MANT_WIDTH-1:0] acc_mant;
  logic [LAT_W-1:0]      wait_q;
  logic [CNT_WIDTH-1:0]  count_inc;

  assign count_inc = count_q + CNT_WIDTH'(1);

  // Handshake and status are pure decodes of the state register.
  assign in_if.in_ready = (state == WAIT_IN);
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign sum_exp        = acc_exp;
  assign sum_mant       = acc_mant;
  assign count          = count_q;

  // NOTE: every register here uses <= so all branches see pre-edge values;
  // the datapath is reset too, so no X ever reaches add_* or sum_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      count_q   <= '0;
      acc_exp   <= '0;
      acc_mant  <= '0;
      wait_q    <= '0;
      add_exp1  <= '0;
      add_mant1 <= '0;
      add_exp2  <= '0;
      add_mant2 <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q     <= len;
            count_q   <= '0;
            acc_exp   <= '0;
            acc_mant  <= '0;
            add_exp2  <= '0;
            add_mant2 <= '0;
            state     <= (len == '0) ? DONE : WAIT_IN;
          end
        end
        WAIT_IN: begin
          if (in_if.in_valid) begin
            if (count_q == '0) begin
              // First operand seeds the accumulator without using the adder.
              acc_exp  <= in_if.in_exp;
              acc_mant <= in_if.in_mant;
              count_q  <= count_inc;
              state    <= (len_q == count_inc) ? DONE : WAIT_IN;
            end else begin
              add_exp1  <= acc_exp;
              add_mant1 <= acc_mant;
              add_exp2  <= in_if.in_exp;
              add_mant2 <= in_if.in_mant;
              wait_q    <= LAT_W'(ADD_LAT);
              state     <= ADD;
            end
          end
        end
        ADD: begin
          if (wait_q == LAT_W'(1)) begin
            acc_exp  <= add_exp;
            acc_mant <= add_mant;
            count_q  <= count_inc;
            state    <= (len_q == count_inc) ? DONE : WAIT_IN;
          end else begin
            wait_q <= wait_q - LAT_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
